// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions.
//   - ALU control codes seen by the EX-stage ALU (ALU_*).
//   - ALUOp codes produced by the main decoder (ALUOP_*).
//   - R-type funct codes understood by the ALU (FUNCT_*).
//   - ex_ctl_t: packed EX-stage control bundle and its bubble value.
package pipe_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ex_ctl_t;

  localparam ex_ctl_t EX_CTL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: all non-clock/reset signals of the ID/EX stage.
//   master modport: the upstream side (decode, hazard unit, MEM/WB feedback)
//                   driving ID inputs, Stall/Flush and forwarding sources.
//   slave modport : the ID/EX stage itself, producing the EX-stage outputs.
// Parameters: WIDTH (datapath width), RA_W (register-address width).
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);

  // Hazard control
  logic             Stall;
  logic             Flush;

  // Decoded ID-stage fields
  logic             IdValid;
  logic             IdRegWrite;
  logic             IdMemRead;
  logic             IdMemWrite;
  logic             IdMemToReg;
  logic             IdALUSrc;
  logic             IdRegDst;
  logic [1:0]       IdALUOp;
  logic [5:0]       IdFunct;
  logic [4:0]       IdShamt;
  logic [WIDTH-1:0] IdRsData;
  logic [WIDTH-1:0] IdRtData;
  logic [WIDTH-1:0] IdImm;
  logic [RA_W-1:0]  IdRs;
  logic [RA_W-1:0]  IdRt;
  logic [RA_W-1:0]  IdRd;

  // Forwarding sources from later stages
  logic             MemRegWrite;
  logic             WbRegWrite;
  logic [RA_W-1:0]  MemRd;
  logic [RA_W-1:0]  WbRd;
  logic [WIDTH-1:0] MemResult;
  logic [WIDTH-1:0] WbResult;

  // EX-stage outputs
  logic [2:0]       Ctl;
  logic [4:0]       Shamt;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic [WIDTH-1:0] ExStoreData;
  logic [RA_W-1:0]  ExWriteReg;
  logic             ExValid;
  logic             ExRegWrite;
  logic             ExMemRead;
  logic             ExMemWrite;
  logic             ExMemToReg;
  logic             ExIllegal;

  modport master (
    output Stall, Flush,
    output IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst,
    output IdALUOp, IdFunct, IdShamt, IdRsData, IdRtData, IdImm, IdRs, IdRt, IdRd,
    output MemRegWrite, WbRegWrite, MemRd, WbRd, MemResult, WbResult,
    input  Ctl, Shamt, DataA, DataB, ExStoreData, ExWriteReg,
    input  ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExIllegal
  );

  modport slave (
    input  Stall, Flush,
    input  IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdALUSrc, IdRegDst,
    input  IdALUOp, IdFunct, IdShamt, IdRsData, IdRtData, IdImm, IdRs, IdRt, IdRd,
    input  MemRegWrite, WbRegWrite, MemRd, WbRd, MemResult, WbResult,
    output Ctl, Shamt, DataA, DataB, ExStoreData, ExWriteReg,
    output ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExIllegal
  );

endinterface

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational ALUOp/funct -> 3-bit ALU control.
//   alu_op  in  2  ALUOp from the main decoder
//   funct   in  6  instruction funct field (only meaningful for R-type)
//   ctl     out 3  ALU control code
//   illegal out 1  R-type with a funct the ALU does not implement
// Unsupported R-type functs decode to ADD so the ALU still sees a defined
// operation; the caller uses 'illegal' to squash the instruction's writes.
module alu_ctl_decode
  import pipe_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD:  ctl = ALU_ADD;
      ALUOP_SUB:  ctl = ALU_SUB;
      ALUOP_RSVD: ctl = ALU_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctl = ALU_ADD;
          FUNCT_SUB: ctl = ALU_SUB;
          FUNCT_AND: ctl = ALU_AND;
          FUNCT_OR:  ctl = ALU_OR;
          FUNCT_SLT: ctl = ALU_SLT;
          FUNCT_SRL: ctl = ALU_SRL;
          default: begin
            ctl     = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ctl     = ALU_ADD;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode and
// EX-hazard operand forwarding.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset (loads the bubble state)
//   bus  id_ex_stage_if.slave: ID inputs, Stall/Flush, MEM/WB forwarding
//        sources in; Ctl/Shamt/DataA/DataB/ExStoreData/ExWriteReg and the
//        Ex* controls out.
// Parameters: WIDTH (datapath width), RA_W (register-address width).
// Build option: define ID_EX_FORWARDING_EN to enable MEM/WB forwarding;
// without it the Mem*/Wb* inputs are ignored and operands come straight
// from the pipeline register.
//
// Stall/Flush semantics: there is no valid/ready handshake on this stage.
// Each rising edge either loads a bubble (Flush, which wins over Stall),
// holds every register (Stall), or loads the ID inputs. The forwarding mux
// sits after the register, so it keeps re-evaluating while stalled.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  // ALU control decode on the ID-side inputs
  logic [2:0] dec_ctl;
  logic       dec_illegal;

  alu_ctl_decode u_alu_ctl_decode (
    .alu_op  (bus.IdALUOp),
    .funct   (bus.IdFunct),
    .ctl     (dec_ctl),
    .illegal (dec_illegal)
  );

  // Incoming control bundle; an illegal R-type must not write anything.
  ex_ctl_t id_ctl;

  always_comb begin
    id_ctl            = EX_CTL_BUBBLE;
    id_ctl.valid      = bus.IdValid;
    id_ctl.reg_write  = bus.IdRegWrite & ~dec_illegal;
    id_ctl.mem_read   = bus.IdMemRead;
    id_ctl.mem_write  = bus.IdMemWrite & ~dec_illegal;
    id_ctl.mem_to_reg = bus.IdMemToReg;
    id_ctl.alu_src    = bus.IdALUSrc;
  end

  // Pipeline registers
  ex_ctl_t          ex_q;
  logic [2:0]       ctl_q;
  logic [4:0]       shamt_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic [RA_W-1:0]  write_reg_q;
  logic             illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= EX_CTL_BUBBLE;
      ctl_q       <= ALU_ADD;
      shamt_q     <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      write_reg_q <= '0;
      illegal_q   <= 1'b0;
    end else if (bus.Flush) begin
      ex_q        <= EX_CTL_BUBBLE;
      ctl_q       <= ALU_ADD;
      shamt_q     <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      write_reg_q <= '0;
      illegal_q   <= 1'b0;
    end else if (!bus.Stall) begin
      ex_q        <= id_ctl;
      ctl_q       <= dec_ctl;
      shamt_q     <= bus.IdShamt;
      rs_data_q   <= bus.IdRsData;
      rt_data_q   <= bus.IdRtData;
      imm_q       <= bus.IdImm;
      rs_q        <= bus.IdRs;
      rt_q        <= bus.IdRt;
      write_reg_q <= bus.IdRegDst ? bus.IdRd : bus.IdRt;
      illegal_q   <= dec_illegal;
    end
  end

  // Operand values after forwarding
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

`ifdef ID_EX_FORWARDING_EN
  logic             mem_reg_write;
  logic             wb_reg_write;
  logic [RA_W-1:0]  mem_rd;
  logic [RA_W-1:0]  wb_rd;
  logic [WIDTH-1:0] mem_result;
  logic [WIDTH-1:0] wb_result;

  assign mem_reg_write = bus.MemRegWrite;
  assign wb_reg_write  = bus.WbRegWrite;
  assign mem_rd        = bus.MemRd;
  assign wb_rd         = bus.WbRd;
  assign mem_result    = bus.MemResult;
  assign wb_result     = bus.WbResult;

  // r0 is hard-wired zero, so a "write" to it is never forwarded.
  // MEM is checked last so it overrides WB: it holds the younger result.
  function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0] r,
                                           input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    res = v;
    if (wb_reg_write && (wb_rd == r) && (r != '0))
      res = wb_result;
    if (mem_reg_write && (mem_rd == r) && (r != '0))
      res = mem_result;
    return res;
  endfunction

  always_comb begin
    fwd_rs = fwd(rs_q, rs_data_q);
    fwd_rt = fwd(rt_q, rt_data_q);
  end
`else
  // Register numbers and MEM/WB feedback have no consumer in this build.
  logic unused_fwd;

  assign unused_fwd = ^{rs_q, rt_q, bus.MemRegWrite, bus.WbRegWrite,
                        bus.MemRd, bus.WbRd, bus.MemResult, bus.WbResult};

  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
  end
`endif

  // Outputs. The ALU shifter operates on DataA, so SRL routes rt there.
  assign bus.Ctl         = ctl_q;
  assign bus.Shamt       = shamt_q;
  assign bus.DataA       = (ctl_q == ALU_SRL) ? fwd_rt : fwd_rs;
  assign bus.DataB       = ex_q.alu_src ? imm_q : fwd_rt;
  assign bus.ExStoreData = fwd_rt;
  assign bus.ExWriteReg  = write_reg_q;
  assign bus.ExValid     = ex_q.valid;
  assign bus.ExRegWrite  = ex_q.reg_write;
  assign bus.ExMemRead   = ex_q.mem_read;
  assign bus.ExMemWrite  = ex_q.mem_write;
  assign bus.ExMemToReg  = ex_q.mem_to_reg;
  assign bus.ExIllegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Directed table of decode vectors, hand-written reset/stall/flush/forwarding
// sequences, then randomized traffic compared with an instruction-level model.
// Honours ID_EX_FORWARDING_EN the same way the design does.
module tb_id_ex_stage;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

  id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // The model remembers the whole ID instruction held in EX (all-zero = bubble)
  // and derives every output from it plus the current MEM/WB inputs.
  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
  } id_t;

  id_t held;
  bit [2:0] rtype_ctl [bit [5:0]];

  function automatic id_t sample_id();
    id_t v;
    v.valid = bus.IdValid;       v.reg_write = bus.IdRegWrite;
    v.mem_read = bus.IdMemRead;  v.mem_write = bus.IdMemWrite;
    v.mem_to_reg = bus.IdMemToReg; v.alu_src = bus.IdALUSrc;
    v.reg_dst = bus.IdRegDst;    v.alu_op = bus.IdALUOp;
    v.funct = bus.IdFunct;       v.shamt = bus.IdShamt;
    v.rs_data = bus.IdRsData;    v.rt_data = bus.IdRtData;
    v.imm = bus.IdImm;           v.rs = bus.IdRs;
    v.rt = bus.IdRt;             v.rd = bus.IdRd;
    return v;
  endfunction

  task automatic drive_id(input id_t v);
    bus.IdValid = v.valid;       bus.IdRegWrite = v.reg_write;
    bus.IdMemRead = v.mem_read;  bus.IdMemWrite = v.mem_write;
    bus.IdMemToReg = v.mem_to_reg; bus.IdALUSrc = v.alu_src;
    bus.IdRegDst = v.reg_dst;    bus.IdALUOp = v.alu_op;
    bus.IdFunct = v.funct;       bus.IdShamt = v.shamt;
    bus.IdRsData = v.rs_data;    bus.IdRtData = v.rt_data;
    bus.IdImm = v.imm;           bus.IdRs = v.rs;
    bus.IdRt = v.rt;             bus.IdRd = v.rd;
  endtask

  task automatic drive_fb(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.MemRegWrite = mw; bus.MemRd = mrd; bus.MemResult = mres;
    bus.WbRegWrite  = ww; bus.WbRd  = wrd; bus.WbResult  = wres;
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] v);
`ifdef ID_EX_FORWARDING_EN
    if (r != 0 && bus.MemRegWrite && bus.MemRd == r) return bus.MemResult;
    if (r != 0 && bus.WbRegWrite && bus.WbRd == r) return bus.WbResult;
`endif
    return v;
  endfunction

  task automatic check_model(input string tag);
    logic [2:0]  c;
    logic        ill;
    logic [31:0] a, b, rs_v, rt_v;
    ill = 1'b0;
    if (held.alu_op == 2'b01) c = 3'b110;
    else if (held.alu_op != 2'b10) c = 3'b010;
    else if (rtype_ctl.exists(held.funct)) c = rtype_ctl[held.funct];
    else begin c = 3'b010; ill = 1'b1; end
    rs_v = fwd_ref(held.rs, held.rs_data);
    rt_v = fwd_ref(held.rt, held.rt_data);
    a = (c == 3'b011) ? rt_v : rs_v;
    b = held.alu_src ? held.imm : rt_v;
    chk({tag, ".Ctl"},         32'(bus.Ctl),        32'(c));
    chk({tag, ".Shamt"},       32'(bus.Shamt),      32'(held.shamt));
    chk({tag, ".DataA"},       bus.DataA,           a);
    chk({tag, ".DataB"},       bus.DataB,           b);
    chk({tag, ".StoreData"},   bus.ExStoreData,     rt_v);
    chk({tag, ".WriteReg"},    32'(bus.ExWriteReg), 32'(held.reg_dst ? held.rd : held.rt));
    chk({tag, ".Valid"},       32'(bus.ExValid),    32'(held.valid));
    chk({tag, ".RegWrite"},    32'(bus.ExRegWrite), 32'(held.reg_write & ~ill));
    chk({tag, ".MemRead"},     32'(bus.ExMemRead),  32'(held.mem_read));
    chk({tag, ".MemWrite"},    32'(bus.ExMemWrite), 32'(held.mem_write & ~ill));
    chk({tag, ".MemToReg"},    32'(bus.ExMemToReg), 32'(held.mem_to_reg));
    chk({tag, ".Illegal"},     32'(bus.ExIllegal),  32'(ill));
  endtask

  // One clock: model follows the register-update priority, then sample #1 later.
  task automatic step();
    @(posedge clk);
    if (rst || bus.Flush) held = '0;
    else if (!bus.Stall) held = sample_id();
    #1;
  endtask

  function automatic id_t random_id();
    id_t v;
    bit [5:0] legal [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000010};
    v = '0;
    v.valid = 1'($urandom);     v.reg_write = 1'($urandom);
    v.mem_read = 1'($urandom);  v.mem_write = 1'($urandom);
    v.mem_to_reg = 1'($urandom); v.alu_src = 1'($urandom);
    v.reg_dst = 1'($urandom);
    v.alu_op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
    v.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
    v.shamt = 5'($urandom);
    v.rs_data = $urandom; v.rt_data = $urandom; v.imm = $urandom;
    v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7));
    v.rd = 5'($urandom_range(0, 31));
    return v;
  endfunction

  task automatic random_fb();
    drive_fb(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  // ---------------- directed decode table ----------------
  typedef struct packed {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        rw, mw;
    logic [2:0]  ctl;
    logic        ill, exrw, exmw;
    logic [31:0] data_a;
  } vec_t;

  vec_t tbl [11];
  id_t  base;

  initial begin
    // table: {alu_op, funct, IdRegWrite, IdMemWrite, Ctl, Illegal, ExRegWrite, ExMemWrite, DataA}
    tbl[0]  = '{2'b10, 6'b100010, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 32'd10};
    tbl[1]  = '{2'b10, 6'b100000, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 32'd10};
    tbl[2]  = '{2'b10, 6'b100100, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'd10};
    tbl[3]  = '{2'b10, 6'b100101, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 32'd10};
    tbl[4]  = '{2'b10, 6'b101010, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 32'd10};
    tbl[5]  = '{2'b10, 6'b000010, 1'b1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 32'd3};
    tbl[6]  = '{2'b10, 6'b000000, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 32'd10};
    tbl[7]  = '{2'b10, 6'b111111, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 32'd10};
    tbl[8]  = '{2'b00, 6'b000010, 1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 32'd10};
    tbl[9]  = '{2'b01, 6'b000000, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 32'd10};
    tbl[10] = '{2'b11, 6'b100010, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 32'd10};

    rtype_ctl[6'b100000] = 3'b010;
    rtype_ctl[6'b100010] = 3'b110;
    rtype_ctl[6'b100100] = 3'b000;
    rtype_ctl[6'b100101] = 3'b001;
    rtype_ctl[6'b101010] = 3'b111;
    rtype_ctl[6'b000010] = 3'b011;

    // ---- reset state, no clock edge yet ----
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive_id('0);
    drive_fb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    held = '0;
    #2;
    check_model("reset");
    #1 rst = 1'b0;

    // ---- decode table ----
    base = '0;
    base.valid = 1'b1; base.reg_dst = 1'b1;
    base.rs = 5'd3; base.rs_data = 32'd10;
    base.rt = 5'd4; base.rt_data = 32'd3;
    base.rd = 5'd9; base.imm = 32'h55; base.shamt = 5'd4;
    foreach (tbl[i]) begin
      id_t v;
      v = base;
      v.alu_op = tbl[i].alu_op; v.funct = tbl[i].funct;
      v.reg_write = tbl[i].rw;  v.mem_write = tbl[i].mw;
      drive_id(v);
      step();
      chk($sformatf("tbl%0d.Ctl", i),      32'(bus.Ctl),        32'(tbl[i].ctl));
      chk($sformatf("tbl%0d.Illegal", i),  32'(bus.ExIllegal),  32'(tbl[i].ill));
      chk($sformatf("tbl%0d.RegWrite", i), 32'(bus.ExRegWrite), 32'(tbl[i].exrw));
      chk($sformatf("tbl%0d.MemWrite", i), 32'(bus.ExMemWrite), 32'(tbl[i].exmw));
      chk($sformatf("tbl%0d.DataA", i),    bus.DataA,           tbl[i].data_a);
      chk($sformatf("tbl%0d.DataB", i),    bus.DataB,           32'd3);
      chk($sformatf("tbl%0d.Shamt", i),    32'(bus.Shamt),      32'd4);
      chk($sformatf("tbl%0d.WriteReg", i), 32'(bus.ExWriteReg), 32'd9);
      check_model($sformatf("tbl%0d", i));
    end

    // ---- forwarding priority ----
    begin
      id_t v;
      v = base;
      v.rs = 5'd5; v.rs_data = 32'h11; v.rt = 5'd6; v.rt_data = 32'h22;
      drive_id(v);
      step();
      drive_fb(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
      #1;
`ifdef ID_EX_FORWARDING_EN
      chk("fwd_mem_prio.DataA", bus.DataA, 32'hAA);
`else
      chk("fwd_mem_prio.DataA", bus.DataA, 32'h11);
`endif
      check_model("fwd_mem_prio");
      bus.MemRegWrite = 1'b0;
      #1;
`ifdef ID_EX_FORWARDING_EN
      chk("fwd_wb.DataA", bus.DataA, 32'hBB);
`else
      chk("fwd_wb.DataA", bus.DataA, 32'h11);
`endif
      check_model("fwd_wb");
      v.rs = 5'd0; v.rs_data = 32'h33;
      drive_id(v);
      drive_fb(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      step();
      chk("fwd_r0.DataA", bus.DataA, 32'h33);
      check_model("fwd_r0");
      drive_fb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    end

    // ---- SRL routes rt to DataA ----
    begin
      id_t v;
      v = base;
      v.funct = 6'b000010; v.alu_op = 2'b10; v.shamt = 5'd4; v.rt_data = 32'h80;
      drive_id(v);
      step();
      chk("srl.Ctl",   32'(bus.Ctl),   32'b011);
      chk("srl.Shamt", 32'(bus.Shamt), 32'd4);
      chk("srl.DataA", bus.DataA,      32'h80);
    end

    // ---- stall 3 cycles while ID changes, then flush+stall ----
    begin
      id_t v;
      v = base;
      v.alu_op = 2'b10; v.funct = 6'b100000; v.reg_write = 1'b1;
      drive_id(v);
      step();
      bus.Stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        drive_id(random_id());
        step();
        chk($sformatf("stall%0d.Valid", k), 32'(bus.ExValid), 32'd1);
        chk($sformatf("stall%0d.DataA", k), bus.DataA,        32'd10);
        check_model($sformatf("stall%0d", k));
      end
      bus.Flush = 1'b1;
      step();
      chk("flush_stall.Valid",    32'(bus.ExValid),    32'd0);
      chk("flush_stall.RegWrite", 32'(bus.ExRegWrite), 32'd0);
      check_model("flush_stall");
      bus.Flush = 1'b0;
      bus.Stall = 1'b0;
    end

    // ---- illegal held through stall, cleared by next legal load ----
    begin
      id_t v;
      v = base;
      v.alu_op = 2'b10; v.funct = 6'b000000; v.reg_write = 1'b1;
      drive_id(v);
      step();
      chk("illegal.Illegal",  32'(bus.ExIllegal),  32'd1);
      chk("illegal.RegWrite", 32'(bus.ExRegWrite), 32'd0);
      chk("illegal.Ctl",      32'(bus.Ctl),        32'b010);
      v.funct = 6'b100100;
      drive_id(v);
      bus.Stall = 1'b1;
      step();
      chk("illegal_hold.Illegal", 32'(bus.ExIllegal), 32'd1);
      bus.Stall = 1'b0;
      step();
      chk("illegal_clr.Illegal", 32'(bus.ExIllegal), 32'd0);
      chk("illegal_clr.Ctl",     32'(bus.Ctl),       32'b000);
    end

    // ---- asynchronous reset mid-stall ----
    bus.Stall = 1'b1;
    step();
    rst = 1'b1;
    held = '0;
    #1;
    chk("rst_async.Valid", 32'(bus.ExValid), 32'd0);
    chk("rst_async.Ctl",   32'(bus.Ctl),     32'b010);
    chk("rst_async.DataA", bus.DataA,        32'd0);
    chk("rst_async.DataB", bus.DataB,        32'd0);
    check_model("rst_async");
    step();
    check_model("rst_held");
    #2 rst = 1'b0;
    bus.Stall = 1'b0;
    drive_id(base);
    step();
    chk("post_rst.Valid", 32'(bus.ExValid), 32'd1);
    check_model("post_rst");

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      drive_id(random_id());
      bus.Stall = ($urandom_range(0, 4) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      random_fb();
      step();
      check_model("rand");
      random_fb();
      #1;
      check_model("rand_fb");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
